// File: rtl/instr_fetch_if.sv
// instr_fetch_if: fetch-stage bus bundling the instruction-memory port, the redirect input and the decode handshake.
//   master (fetch stage): drives imem_req/imem_addr, instr_valid/instr/instr_pc/pc_plus4, misaligned_fault
//   slave  (environment): drives imem_ready/imem_rvalid/imem_rdata, redirect/redirect_pc, instr_ready
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        misaligned_fault;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4, misaligned_fault,
    input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, pc_plus4, misaligned_fault,
    output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, issues one instruction-memory read at a time and hands each word to decode.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : instr_fetch_if.master (memory request/response, redirect, decode valid/ready, misaligned fault)
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_fetch_if.master  bus
);
  typedef enum logic [2:0] {BOOT, REQ, WAIT, DISCARD, HOLD} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_pc, w_pc_next, r_instr, r_instr_pc, r_pc_plus4;
  logic        r_valid, r_fault;
  logic        w_redir, w_bad, w_accept, w_xfer, w_capture;
  always_comb begin
    w_redir   = bus.redirect && (bus.redirect_pc[1:0] == 2'b00);
    w_bad     = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
    w_accept  = (r_state == REQ) && bus.imem_ready;
    w_xfer    = r_valid && bus.instr_ready;
    // a redirect landing on the response cycle drops the stale word
    w_capture = (r_state == WAIT) && bus.imem_rvalid && !w_redir;
    // a transfer coinciding with a redirect still completes, but the redirect target wins the PC
    w_pc_next = w_redir ? bus.redirect_pc : w_xfer ? r_pc + 32'd4 : r_pc;
    w_next    = r_state;
    unique case (r_state)
      BOOT:    w_next = REQ;
      REQ:     w_next = w_accept ? (w_redir ? DISCARD : WAIT) : REQ;
      WAIT:    w_next = bus.imem_rvalid ? (w_redir ? REQ : HOLD) : (w_redir ? DISCARD : WAIT);
      // a response arriving alongside a fresh redirect still retires the outstanding read
      DISCARD: w_next = bus.imem_rvalid ? REQ : DISCARD;
      HOLD:    w_next = (w_redir || w_xfer) ? REQ : HOLD;
      default: w_next = BOOT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= BOOT;
      r_pc       <= RESET_PC;
      r_instr    <= 32'h0000_0013;
      r_instr_pc <= RESET_PC;
      r_pc_plus4 <= RESET_PC + 32'd4;
      r_valid    <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_pc    <= w_pc_next;
      r_valid <= (w_next == HOLD);
      r_fault <= w_bad;
      if (w_capture) begin
        r_instr    <= bus.imem_rdata;
        r_instr_pc <= r_pc;
        r_pc_plus4 <= r_pc + 32'd4;
      end
    end
  end
  assign bus.imem_req         = (r_state == REQ);
  assign bus.imem_addr        = r_pc;
  assign bus.instr_valid      = r_valid;
  assign bus.instr            = r_instr;
  assign bus.instr_pc         = r_instr_pc;
  assign bus.pc_plus4         = r_pc_plus4;
  assign bus.misaligned_fault = r_fault;
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch with a latency-programmable memory model.
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   lat = 1;
  int   edge_cnt = 0;
  int   first_acc = 0;
  int   cnt = 0;
  logic pend = 1'b0;
  logic [31:0] paddr = 32'h0;
  logic [31:0] acc_addr[$];
  logic [31:0] xfer_pc[$];
  logic [31:0] xfer_instr[$];
  int   na, xs, as;

  instr_fetch_if bus();
  instr_fetch #(.RESET_PC(32'h0000_1000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // memory contents: word at address a is ~a
  assign bus.imem_ready  = 1'b1;
  assign bus.imem_rvalid = pend && (cnt == 0);
  assign bus.imem_rdata  = bus.imem_rvalid ? ~paddr : 32'hDEAD_BEEF;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else begin
      if (pend) begin
        if (cnt == 0) pend <= 1'b0;
        else cnt <= cnt - 1;
      end
      if (bus.imem_req && bus.imem_ready) begin
        pend  <= 1'b1;
        cnt   <= lat - 1;
        paddr <= bus.imem_addr;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      edge_cnt  <= 0;
      first_acc <= 0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if (bus.imem_req && bus.imem_ready) begin
        acc_addr.push_back(bus.imem_addr);
        if (first_acc == 0) first_acc <= edge_cnt + 1;
      end
      if (bus.instr_valid && bus.instr_ready) begin
        xfer_pc.push_back(bus.instr_pc);
        xfer_instr.push_back(bus.instr);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!bus.instr_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(bus.instr_valid), 32'd1);
  endtask

  task automatic wait_xfer(input string tag, input int n);
    int k = 0;
    while (xfer_pc.size() < n && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(xfer_pc.size()), 32'(n));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(bus.imem_req), 32'd0);
    chk({tag, "_addr"},  bus.imem_addr, 32'h0000_1000);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_instr"}, bus.instr, 32'h0000_0013);
    chk({tag, "_ipc"},   bus.instr_pc, 32'h0000_1000);
    chk({tag, "_pc4"},   bus.pc_plus4, 32'h0000_1004);
    chk({tag, "_fault"}, 32'(bus.misaligned_fault), 32'd0);
  endtask

  initial begin
    bus.instr_ready = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;
    chk("boot_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    chk("boot_req_e1", 32'(bus.imem_req), 32'd1);
    chk("boot_addr_e1", bus.imem_addr, 32'h0000_1000);
    // straight-line fetch with zero-wait memory
    wait_xfer("seq_xfers", 3);
    chk("first_acc_edge", 32'(first_acc), 32'd2);
    chk("acc0", acc_addr[0], 32'h0000_1000);
    chk("acc1", acc_addr[1], 32'h0000_1004);
    chk("acc2", acc_addr[2], 32'h0000_1008);
    chk("xpc2", xfer_pc[2], 32'h0000_1008);
    chk("xin0", xfer_instr[0], ~32'h0000_1000);
    chk("xin1", xfer_instr[1], ~32'h0000_1004);
    chk("xin2", xfer_instr[2], ~32'h0000_1008);
    // backpressure
    bus.instr_ready = 1'b0;
    wait_valid("bp_valid");
    na = acc_addr.size();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.instr_valid), 32'd1);
      chk("bp_hold_ipc", bus.instr_pc, 32'h0000_100C);
      chk("bp_hold_instr", bus.instr, ~32'h0000_100C);
      chk("bp_no_req", 32'(bus.imem_req), 32'd0);
    end
    chk("bp_no_acc", 32'(acc_addr.size()), 32'(na));
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("bp_next_req", 32'(bus.imem_req), 32'd1);
    chk("bp_next_addr", bus.imem_addr, 32'h0000_1010);
    chk("bp_xfer_cnt", 32'(xfer_pc.size()), 32'd4);
    // in-flight squash with 3-cycle latency
    lat = 3;
    @(negedge clk);
    @(negedge clk);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_2000;
    @(negedge clk);
    bus.redirect = 1'b0;
    lat = 1;
    chk("sq_discard_noreq", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    chk("sq_req_addr", bus.imem_addr, 32'h0000_2000);
    chk("sq_noinstr", 32'(bus.instr_valid), 32'd0);
    wait_xfer("sq_xfers", 5);
    chk("sq_acc", acc_addr[5], 32'h0000_2000);
    chk("sq_xpc", xfer_pc[4], 32'h0000_2000);
    chk("sq_xin", xfer_instr[4], ~32'h0000_2000);
    // redirect accepted-request, then redirect coincident with transfer
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_1008;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    bus.redirect = 1'b0;
    wait_valid("rx_valid");
    chk("rx_ipc", bus.instr_pc, 32'h0000_1008);
    chk("rx_instr", bus.instr, ~32'h0000_1008);
    chk("rx_acc_dropped", acc_addr[6], 32'h0000_2004);
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_3000;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("rx_clear_valid", 32'(bus.instr_valid), 32'd0);
    chk("rx_req", 32'(bus.imem_req), 32'd1);
    chk("rx_addr", bus.imem_addr, 32'h0000_3000);
    chk("rx_xfer_cnt", 32'(xfer_pc.size()), 32'd6);
    chk("rx_xpc", xfer_pc[5], 32'h0000_1008);
    // misaligned redirect
    chk("mis_fault_pre", 32'(bus.misaligned_fault), 32'd0);
    bus.redirect_pc = 32'h0000_2002;
    bus.instr_ready = 1'b0;
    @(negedge clk);
    bus.redirect = 1'b0;
    chk("mis_fault_hi", 32'(bus.misaligned_fault), 32'd1);
    @(negedge clk);
    chk("mis_fault_lo", 32'(bus.misaligned_fault), 32'd0);
    wait_valid("mis_valid");
    chk("mis_acc", acc_addr[8], 32'h0000_3000);
    chk("mis_ipc", bus.instr_pc, 32'h0000_3000);
    // wrap-around
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFC;
    bus.instr_ready = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b0;
    bus.instr_ready = 1'b0;
    chk("wr_xpc", xfer_pc[6], 32'h0000_3000);
    wait_valid("wr_valid");
    chk("wr_ipc", bus.instr_pc, 32'hFFFF_FFFC);
    chk("wr_pc4", bus.pc_plus4, 32'h0000_0000);
    chk("wr_instr", bus.instr, 32'h0000_0003);
    bus.instr_ready = 1'b1;
    @(negedge clk);
    chk("wr_req", 32'(bus.imem_req), 32'd1);
    chk("wr_addr", bus.imem_addr, 32'h0000_0000);
    // reset during an outstanding fetch
    lat = 3;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset("mrst");
    @(negedge clk);
    lat = 1;
    xs = xfer_pc.size();
    as = acc_addr.size();
    rst_n = 1'b1;
    wait_xfer("mrst_xfers", xs + 1);
    chk("mrst_first_acc", 32'(first_acc), 32'd2);
    chk("mrst_acc", acc_addr[as], 32'h0000_1000);
    chk("mrst_xpc", xfer_pc[xs], 32'h0000_1000);
    chk("mrst_xin", xfer_instr[xs], ~32'h0000_1000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
